cache_mem_arbiter: RTL and testbench

// Shares the single-word, combinational-read main memory port between N_REQ cache

---
 rtl/cache_mem_arbiter_if.sv | 29 ++
 rtl/cache_mem_arbiter.sv | 121 ++++++++++++
 tb/tb_cache_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_arbiter_if.sv
// Bundle between the cache controllers, the line arbiter and the single-word memory port.
// The slave modport is the arbiter; master is the requester/memory environment.
interface cache_mem_arbiter_if #(
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned LINE_WIDTH = 4
);
    logic [N_REQ-1:0]      req;
    logic [N_REQ-1:0]      req_write;
    logic [32*N_REQ-1:0]   req_addr;
    logic [32*N_REQ-1:0]   req_wdata;
    logic [N_REQ-1:0]      gnt;
    logic [LINE_WIDTH-1:0] beat;
    logic [N_REQ-1:0]      done;
    logic [31:0]           rdata;
    logic                  mwrite_en;
    logic [31:0]           maddr;
    logic [31:0]           mdata;
    logic [31:0]           mout;

    modport slave (
        input  req, req_write, req_addr, req_wdata, mout,
        output gnt, beat, done, rdata, mwrite_en, maddr, mdata
    );

    modport master (
        output req, req_write, req_addr, req_wdata, mout,
        input  gnt, beat, done, rdata, mwrite_en, maddr, mdata
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter granting the memory port one whole cache line at a time and
// generating the per-beat word address from the owner's line base.
module cache_mem_arbiter #(
    parameter int unsigned  N_REQ      = 2,
    parameter int unsigned  LINE_WIDTH = 4,
    localparam int unsigned BEATS      = 2 ** (LINE_WIDTH - 2)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    cache_mem_arbiter_if.slave bus
);
    localparam int unsigned IdxW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned BeatW = LINE_WIDTH - 2;

    typedef enum logic [0:0] {StIdle, StXfer} state_e;

    state_e                  state_q, state_d;
    logic [N_REQ-1:0]        gnt_q, gnt_d;
    logic [IdxW-1:0]         owner_q, owner_d;
    logic [IdxW-1:0]         last_q, last_d;
    logic [BeatW-1:0]        beat_q, beat_d;
    logic [IdxW-1:0]         pick, idx;
    logic                    found;
    logic [31-LINE_WIDTH:0]  own_base;
    logic [31:0]             own_wdata;
    logic                    own_req, own_write;
    logic                    xfer, active, last_beat;

    // Scan last+1, last+2, ... so the previous owner has lowest priority.
    always_comb begin
        pick  = last_q;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = IdxW'((32'(last_q) + i) % N_REQ);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        own_base  = '0;
        own_wdata = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (owner_q == IdxW'(i)) begin
                own_base  = bus.req_addr[32*i+LINE_WIDTH +: 32-LINE_WIDTH];
                own_wdata = bus.req_wdata[32*i +: 32];
            end
        end
    end

    assign own_req   = bus.req[owner_q];
    assign own_write = bus.req_write[owner_q];
    assign xfer      = !reset && (state_q == StXfer);
    // A beat happens only when enabled and the owner still holds its request.
    assign active    = xfer && en && own_req;
    assign last_beat = (beat_q == BeatW'(BEATS - 1));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        beat_d  = beat_q;
        if (en) begin
            unique case (state_q)
                StIdle: begin
                    if (found) begin
                        state_d = StXfer;
                        owner_d = pick;
                        gnt_d   = N_REQ'(1) << pick;
                        beat_d  = '0;
                    end
                end
                StXfer: begin
                    if (!own_req || last_beat) begin
                        state_d = StIdle;
                        last_d  = owner_q;
                        gnt_d   = '0;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            owner_q <= '0;
            last_q  <= IdxW'(N_REQ - 1);
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        bus.gnt       = gnt_q;
        bus.rdata     = bus.mout;
        bus.beat      = xfer ? {beat_q, 2'b00} : '0;
        bus.maddr     = xfer ? {own_base, beat_q, 2'b00} : '0;
        bus.mdata     = xfer ? own_wdata : '0;
        bus.mwrite_en = active && own_write;
        bus.done      = '0;
        if (active && last_beat) begin
            bus.done[owner_q] = 1'b1;
        end
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a cycle-accurate scoreboard of expected outputs
// is filled as each scenario is driven and drained once per clock.
module tb_cache_mem_arbiter;
    localparam int unsigned N_REQ      = 2;
    localparam int unsigned LINE_WIDTH = 4;
    localparam int unsigned BEATS      = 4;

    logic clk = 1'b0;
    logic reset;
    logic en;
    logic mem_clr;

    always #5 clk = ~clk;

    cache_mem_arbiter_if #(.N_REQ(N_REQ), .LINE_WIDTH(LINE_WIDTH)) bus ();

    cache_mem_arbiter #(
        .N_REQ     (N_REQ),
        .LINE_WIDTH(LINE_WIDTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .bus  (bus)
    );

    // Memory model: unwritten words read back a value derived from their index.
    logic [31:0]   mem [1024];
    logic [1023:0] written;

    function automatic logic [31:0] init_val(input logic [9:0] i);
        return 32'h5A00_0000 | {22'd0, i};
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return written[a[11:2]] ? mem[a[11:2]] : init_val(a[11:2]);
    endfunction

    always_comb begin
        bus.mout = written[bus.maddr[11:2]] ? mem[bus.maddr[11:2]] : init_val(bus.maddr[11:2]);
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            written <= '0;
        end else if (bus.mwrite_en) begin
            mem[bus.maddr[11:2]]     <= bus.mdata;
            written[bus.maddr[11:2]] <= 1'b1;
        end
    end

    typedef struct {
        logic [1:0]  gnt;
        logic [1:0]  done;
        logic        we;
        logic [31:0] maddr;
        logic [3:0]  beat;
        logic [31:0] rdata;
        logic [31:0] mdata;
        bit          chk_we, chk_addr, chk_beat, chk_rdata, chk_mdata;
        int          step;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_pass  = 0;
    int unsigned n_fail  = 0;
    int unsigned n_total = 0;
    int          step    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t blank(input logic [1:0] g, input logic [1:0] d);
        exp_t e;
        e.gnt = g;      e.done = d;     e.we = 1'b0;
        e.maddr = '0;   e.beat = '0;    e.rdata = '0;    e.mdata = '0;
        e.chk_we = 1'b1;    e.chk_addr = 1'b0;  e.chk_beat = 1'b1;
        e.chk_rdata = 1'b0; e.chk_mdata = 1'b0;
        e.step = step;
        return e;
    endfunction

    task automatic push_idle(input int n);
        for (int k = 0; k < n; k++) sb.push_back(blank(2'b00, 2'b00));
    endtask

    task automatic push_beat(input int owner, input logic [31:0] base, input int b,
                             input logic wr, input logic [31:0] wbase);
        exp_t e;
        e = blank(2'(1 << owner), (b == BEATS - 1) ? 2'(1 << owner) : 2'b00);
        e.we        = wr;
        e.maddr     = {base[31:4], 2'(b), 2'b00};
        e.chk_addr  = 1'b1;
        e.beat      = {2'(b), 2'b00};
        e.rdata     = model_rd(e.maddr);
        e.chk_rdata = !wr;
        e.mdata     = wbase + 32'(b);
        e.chk_mdata = wr;
        sb.push_back(e);
    endtask

    task automatic push_line(input int owner, input logic [31:0] base, input logic wr,
                             input logic [31:0] wbase);
        for (int b = 0; b < BEATS; b++) push_beat(owner, base, b, wr, wbase);
    endtask

    task automatic cyc();
        exp_t e;
        @(negedge clk);
        n_total++;
        assert (sb.size() > 0) n_pass++;
        else begin
            n_fail++;
            $error("FAIL sb_underflow: observed size 0 expected >0");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("s%0d_gnt", e.step), 32'(bus.gnt), 32'(e.gnt));
            check($sformatf("s%0d_done", e.step), 32'(bus.done), 32'(e.done));
            if (e.chk_we) check($sformatf("s%0d_we", e.step), 32'(bus.mwrite_en), 32'(e.we));
            if (e.chk_addr) check($sformatf("s%0d_maddr", e.step), bus.maddr, e.maddr);
            if (e.chk_beat) check($sformatf("s%0d_beat", e.step), 32'(bus.beat), 32'(e.beat));
            if (e.chk_rdata) check($sformatf("s%0d_rdata", e.step), bus.rdata, e.rdata);
            if (e.chk_mdata) check($sformatf("s%0d_mdata", e.step), bus.mdata, e.mdata);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    initial begin
        exp_t r;
        mem_clr       = 1'b1;
        reset         = 1'b1;
        en            = 1'b1;
        bus.req       = 2'b11;
        bus.req_write = 2'b00;
        bus.req_addr  = {32'h0000_0100, 32'h1234_5678};
        bus.req_wdata = '0;

        // Reset with both requests high: everything quiet.
        step = 1;
        for (int k = 0; k < 2; k++) begin
            r = blank(2'b00, 2'b00);
            r.chk_addr = 1'b1;
            sb.push_back(r);
        end
        run(2);
        reset   = 1'b0;
        mem_clr = 1'b0;

        // Contention with both requests held: 0,1,0,1 with one idle cycle between lines.
        step = 2;
        for (int k = 0; k < 4; k++) begin
            push_idle(1);
            if (k % 2 == 0) push_line(0, 32'h1234_5678, 1'b0, 32'h0);
            else            push_line(1, 32'h0000_0100, 1'b0, 32'h0);
        end
        run(20);
        bus.req = 2'b00;
        push_idle(2);
        run(2);

        // Write-back burst from requester 1.
        step = 3;
        bus.req               = 2'b10;
        bus.req_write         = 2'b10;
        bus.req_addr[63:32]   = 32'h0000_0200;
        push_idle(1);
        push_line(1, 32'h0000_0200, 1'b1, 32'hA0A0_0000);
        push_idle(1);
        run(1);
        for (int b = 0; b < BEATS; b++) begin
            bus.req_wdata[63:32] = 32'hA0A0_0000 + 32'(b);
            run(1);
        end
        bus.req = 2'b00;
        run(1);
        for (int b = 0; b < BEATS; b++) begin
            check($sformatf("s3_mem%0d", b), model_rd(32'h200 + 32'(4 * b)),
                  32'hA0A0_0000 + 32'(b));
        end

        // Abort: requester 0 drops its write request at beat 2; requester 1 is waiting.
        step = 4;
        bus.req       = 2'b11;
        bus.req_write = 2'b01;
        bus.req_addr  = {32'h0000_0400, 32'h0000_0300};
        push_idle(1);
        push_beat(0, 32'h0000_0300, 0, 1'b1, 32'hB0B0_0000);
        push_beat(0, 32'h0000_0300, 1, 1'b1, 32'hB0B0_0000);
        r = blank(2'b01, 2'b00);
        r.beat = 4'd8;
        sb.push_back(r);
        push_idle(1);
        push_line(1, 32'h0000_0400, 1'b0, 32'h0);
        push_idle(1);
        run(1);
        for (int b = 0; b < 2; b++) begin
            bus.req_wdata[31:0] = 32'hB0B0_0000 + 32'(b);
            run(1);
        end
        bus.req = 2'b10;
        run(6);
        bus.req = 2'b00;
        run(1);
        check("s4_mem0", model_rd(32'h300), 32'hB0B0_0000);
        check("s4_mem1", model_rd(32'h304), 32'hB0B0_0001);
        check("s4_mem2_untouched", model_rd(32'h308), 32'h5A00_00C2);

        // Stall: en low for two cycles at beat 2 of a write-back.
        step = 5;
        bus.req            = 2'b01;
        bus.req_write      = 2'b01;
        bus.req_addr[31:0] = 32'h0000_0500;
        push_idle(1);
        push_beat(0, 32'h0000_0500, 0, 1'b1, 32'hC0C0_0000);
        push_beat(0, 32'h0000_0500, 1, 1'b1, 32'hC0C0_0000);
        for (int k = 0; k < 2; k++) begin
            r = blank(2'b01, 2'b00);
            r.beat     = 4'd8;
            r.maddr    = 32'h0000_0508;
            r.chk_addr = 1'b1;
            sb.push_back(r);
        end
        push_beat(0, 32'h0000_0500, 2, 1'b1, 32'hC0C0_0000);
        push_beat(0, 32'h0000_0500, 3, 1'b1, 32'hC0C0_0000);
        push_idle(1);
        run(1);
        for (int b = 0; b < 2; b++) begin
            bus.req_wdata[31:0] = 32'hC0C0_0000 + 32'(b);
            run(1);
        end
        bus.req_wdata[31:0] = 32'hC0C0_0002;
        en = 1'b0;
        run(2);
        en = 1'b1;
        run(1);
        bus.req_wdata[31:0] = 32'hC0C0_0003;
        run(1);
        bus.req = 2'b00;
        run(1);
        check("s5_mem2", model_rd(32'h508), 32'hC0C0_0002);
        check("s5_mem3", model_rd(32'h50C), 32'hC0C0_0003);

        // Reset at beat 1 of a fetch: back to idle with no done.
        step = 6;
        bus.req            = 2'b01;
        bus.req_write      = 2'b00;
        bus.req_addr[31:0] = 32'h0000_0600;
        push_idle(1);
        push_beat(0, 32'h0000_0600, 0, 1'b0, 32'h0);
        r = blank(2'b01, 2'b00);
        r.chk_we   = 1'b0;
        r.chk_beat = 1'b0;
        sb.push_back(r);
        push_idle(2);
        run(2);
        reset = 1'b1;
        run(1);
        reset   = 1'b0;
        bus.req = 2'b00;
        run(2);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
